// File: rtl/leve_tb_pkg.sv
// Shared types and the riscv-tests exit-code decoder for the tohost monitor.
package leve_tb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mon_state_t;

   typedef enum logic [1:0] {
      EX_NONE = 2'd0,
      EX_PASS = 2'd1,
      EX_FAIL = 2'd2
   } exit_kind_t;

   // Odd codes are exits (code = test_num << 1 | 1); even codes are syscalls.
   function automatic exit_kind_t decode_exit(input logic [63:0] code,
                                              input logic [63:0] pass_code);
      if (code == pass_code) return EX_PASS;
      if (code[0])           return EX_FAIL;
      return EX_NONE;
   endfunction

endpackage

// File: rtl/tb_host_chan.sv
// One monitored tohost channel: records its first exit report and the code it carried.
module tb_host_chan
   import leve_tb_pkg::*;
#(
   parameter int unsigned       XLEN      = 32,
   parameter logic [XLEN-1:0]   PASS_CODE = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            accept_i,
   input  logic            we_i,
   input  logic [XLEN-1:0] code_i,
   output logic            reported_nxt_o,
   output logic            pass_nxt_o,
   output logic            fail_now_o,
   output logic [XLEN-1:0] code_nxt_o
);

   logic            reported_q, reported_d;
   logic            pass_q, pass_d;
   logic [XLEN-1:0] code_q, code_d;
   exit_kind_t      kind;
   logic            report_now;

   assign kind       = decode_exit(64'(code_i), 64'(PASS_CODE));
   assign report_now = accept_i & we_i & ~reported_q & (kind != EX_NONE);

   assign reported_d = reported_q | report_now;
   assign pass_d     = pass_q | (report_now & (kind == EX_PASS));
   assign code_d     = report_now ? code_i : code_q;

   // Next-state views let the aggregator decide in the same cycle as the write.
   assign reported_nxt_o = reported_d;
   assign pass_nxt_o     = pass_d;
   assign fail_now_o     = report_now & (kind == EX_FAIL);
   assign code_nxt_o     = code_d;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         reported_q <= 1'b0;
         pass_q     <= 1'b0;
         code_q     <= '0;
      end else begin
         reported_q <= reported_d;
         pass_q     <= pass_d;
         code_q     <= code_d;
      end
   end

endmodule

// File: rtl/tb_host_monitor.sv
// Multi-channel tohost end-of-test detector with verdict aggregation and watchdog.
// Optional: define TB_HOST_MONITOR_FINISH_EN to print the verdict and $finish on DONE.
module tb_host_monitor
   import leve_tb_pkg::*;
#(
   parameter int unsigned     NCH       = 1,
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] PASS_CODE = 1,
   parameter int unsigned     TIMEOUT   = 1000000,
   parameter int unsigned     CNT_W     = 32,
   parameter bit              WAIT_ALL  = 1'b0
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      ENABLE,
   input  logic [NCH-1:0]            TOHOST_WE,
   input  logic [NCH*XLEN-1:0]       TOHOST,
   output logic                      DONE,
   output logic                      PASS,
   output logic                      FAIL,
   output logic                      TIMEOUT_O,
   output logic [$clog2(NCH):0]      FAIL_CH,
   output logic [XLEN-1:0]           EXIT_CODE,
   output logic [XLEN-2:0]           TEST_NUM,
   output logic [CNT_W-1:0]          CYCLES
);

   localparam int unsigned      FCW     = $clog2(NCH) + 1;
   localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   mon_state_t       state_q, state_d;
   logic             accept;
   logic [NCH-1:0]   rep_nxt, pass_nxt, fail_now;
   logic [XLEN-1:0]  code_nxt [NCH];

   logic             fail_seen_q, fail_seen_d;
   logic [FCW-1:0]   first_fail_q, first_fail_d;
   logic [FCW-1:0]   new_fail_idx;
   logic [XLEN-1:0]  sel_code;

   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   logic             timeout_q, timeout_d;
   logic [FCW-1:0]   fail_ch_q, fail_ch_d;
   logic [XLEN-1:0]  exit_code_q, exit_code_d;
   logic [XLEN-2:0]  test_num_q, test_num_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;

   assign accept = (state_q == RUN) & ENABLE;

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      tb_host_chan #(
         .XLEN      (XLEN),
         .PASS_CODE (PASS_CODE)
      ) u_chan (
         .clk_i          (CLK),
         .rst_i          (RST),
         .accept_i       (accept),
         .we_i           (TOHOST_WE[g]),
         .code_i         (TOHOST[g*XLEN +: XLEN]),
         .reported_nxt_o (rep_nxt[g]),
         .pass_nxt_o     (pass_nxt[g]),
         .fail_now_o     (fail_now[g]),
         .code_nxt_o     (code_nxt[g])
      );
   end

   // Lowest index among this cycle's new fails; an earlier latched fail is kept.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      new_fail_idx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (fail_now[i]) new_fail_idx = FCW'(i);
      end
      fail_seen_d  = fail_seen_q | (|fail_now);
      first_fail_d = fail_seen_q ? first_fail_q : new_fail_idx;
      sel_code     = '0;
      for (int i = 0; i < NCH; i++) begin
         if (FCW'(i) == first_fail_d) sel_code = code_nxt[i];
      end
   end

   always_comb begin
      state_d     = state_q;
      done_d      = done_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      timeout_d   = timeout_q;
      fail_ch_d   = fail_ch_q;
      exit_code_d = exit_code_q;
      cycles_d    = cycles_q;
      unique case (state_q)
         IDLE: if (ENABLE) state_d = RUN;
         RUN: begin
            if (ENABLE) begin
               if (fail_seen_d && (!WAIT_ALL || (&rep_nxt))) begin
                  state_d     = leve_tb_pkg::DONE;
                  done_d      = 1'b1;
                  fail_d      = 1'b1;
                  fail_ch_d   = first_fail_d;
                  exit_code_d = sel_code;
               end else if (&pass_nxt) begin
                  state_d     = leve_tb_pkg::DONE;
                  done_d      = 1'b1;
                  pass_d      = 1'b1;
                  fail_ch_d   = '0;
                  exit_code_d = PASS_CODE;
               end else if ((TIMEOUT != 0) && (cycles_q == TO_LAST)) begin
                  state_d   = leve_tb_pkg::DONE;
                  done_d    = 1'b1;
                  timeout_d = 1'b1;
               end else if (cycles_q != '1) begin
                  cycles_d = cycles_q + 1'b1;
               end
            end
         end
         default: state_d = state_q;
      endcase
      test_num_d = exit_code_d[XLEN-1:1];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         fail_seen_q  <= 1'b0;
         first_fail_q <= '0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         timeout_q    <= 1'b0;
         fail_ch_q    <= '0;
         exit_code_q  <= '0;
         test_num_q   <= '0;
         cycles_q     <= '0;
      end else begin
         state_q      <= state_d;
         fail_seen_q  <= fail_seen_d;
         first_fail_q <= first_fail_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         timeout_q    <= timeout_d;
         fail_ch_q    <= fail_ch_d;
         exit_code_q  <= exit_code_d;
         test_num_q   <= test_num_d;
         cycles_q     <= cycles_d;
      end
   end

`ifdef TB_HOST_MONITOR_FINISH_EN
   always_ff @(posedge CLK) begin
      if (!RST && done_d && !done_q) begin
         if (pass_d)
            $display("[TESTBENCH] [PASS] ch %0d exit code %08H test %0d", fail_ch_d, exit_code_d, test_num_d);
         else if (fail_d)
            $display("[TESTBENCH] [FAIL] ch %0d exit code %08H test %0d", fail_ch_d, exit_code_d, test_num_d);
         else
            $display("[TESTBENCH] [TIMEOUT] cycles %0d", cycles_d);
         $finish;
      end
   end
`else
`endif

   assign DONE      = done_q;
   assign PASS      = pass_q;
   assign FAIL      = fail_q;
   assign TIMEOUT_O = timeout_q;
   assign FAIL_CH   = fail_ch_q;
   assign EXIT_CODE = exit_code_q;
   assign TEST_NUM  = test_num_q;
   assign CYCLES    = cycles_q;

endmodule
